// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the frame-buffer read arbiter: read-tag layout,
// freeze FSM states and frame geometry.
package fb_arb_pkg;

    localparam int unsigned FB_WIDTH  = 320;
    localparam int unsigned FB_HEIGHT = 240;

    localparam logic OWNER_DISP = 1'b0;
    localparam logic OWNER_PROC = 1'b1;

    typedef enum logic [1:0] {
        RUN,
        ARMED,
        FROZEN,
        DRAIN
    } freeze_state_t;

    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;

endpackage

// File: rtl/fb_read_arbiter_if.sv
// Bundle of the display, processor, BRAM port B and camera-freeze signals seen by
// fb_read_arbiter; slave is the arbiter side, master the surrounding system.
interface fb_read_arbiter_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 16
);
    logic              disp_valid_in;
    logic [ADDR_W-1:0] disp_addr_in;
    logic [DATA_W-1:0] disp_data_out;
    logic              disp_data_valid_out;
    logic              proc_req_in;
    logic [ADDR_W-1:0] proc_addr_in;
    logic              proc_gnt_out;
    logic [DATA_W-1:0] proc_data_out;
    logic              proc_data_valid_out;
    logic              proc_starve_out;
    logic              bram_en_out;
    logic [ADDR_W-1:0] bram_addr_out;
    logic [DATA_W-1:0] bram_data_in;
    logic              freeze_req_in;
    logic              frame_done_in;
    logic              cam_we_in;
    logic              cam_we_out;
    logic              frozen_out;

    modport slave (
        input  disp_valid_in, disp_addr_in, proc_req_in, proc_addr_in, bram_data_in,
               freeze_req_in, frame_done_in, cam_we_in,
        output disp_data_out, disp_data_valid_out, proc_gnt_out, proc_data_out,
               proc_data_valid_out, proc_starve_out, bram_en_out, bram_addr_out,
               cam_we_out, frozen_out
    );

    modport master (
        output disp_valid_in, disp_addr_in, proc_req_in, proc_addr_in, bram_data_in,
               freeze_req_in, frame_done_in, cam_we_in,
        input  disp_data_out, disp_data_valid_out, proc_gnt_out, proc_data_out,
               proc_data_valid_out, proc_starve_out, bram_en_out, bram_addr_out,
               cam_we_out, frozen_out
    );

endinterface

// File: rtl/fb_freeze_fsm.sv
// Freezes camera writes to port A on a frame boundary so the processor sees an
// untorn frame; writes resume only at the next frame boundary after release.
module fb_freeze_fsm
    import fb_arb_pkg::*;
(
    input  logic clk_in,
    input  logic rst_in,
    input  logic freeze_req_in,
    input  logic frame_done_in,
    input  logic cam_we_in,
    output logic cam_we_out,
    output logic frozen_out
);

    freeze_state_t state_q, state_d;
    logic          frozen_q, frozen_d;
    logic          block_q, block_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (freeze_req_in) state_d = frame_done_in ? FROZEN : ARMED;
            ARMED:   if (!freeze_req_in) state_d = RUN;
                     else if (frame_done_in) state_d = FROZEN;
            FROZEN:  if (!freeze_req_in) state_d = DRAIN;
            DRAIN:   if (freeze_req_in) state_d = FROZEN;
                     else if (frame_done_in) state_d = RUN;
            default: state_d = RUN;
        endcase
        frozen_d = (state_d == FROZEN);
        block_d  = (state_d == FROZEN) || (state_d == DRAIN);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q  <= RUN;
            frozen_q <= 1'b0;
            block_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            frozen_q <= frozen_d;
            block_q  <= block_d;
        end
    end

    assign cam_we_out = rst_in & cam_we_in & ~block_q;
    assign frozen_out = frozen_q;

endmodule

// File: rtl/fb_read_arbiter.sv
// Shares frame-buffer read port B between the display (strict priority) and the
// QR processor, routes returning data by tag and flags processor starvation.
module fb_read_arbiter
    import fb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 17,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned READ_LAT     = 2,
    parameter int unsigned STARVE_LIMIT = 1024
) (
    input logic            clk_in,
    input logic            rst_in,
    fb_read_arbiter_if.slave bus
);

    localparam int unsigned    CntW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    logic                          disp_sel, proc_sel;
    logic [ADDR_W-1:0]             addr_q, addr_d;
    rd_tag_t [READ_LAT-1:0]        tag_q, tag_d;
    rd_tag_t                       tag_out;
    logic [CntW-1:0]               cnt_q, cnt_d;
    logic                          starve_q, starve_d;

    always_comb begin
        // Qualified by reset so port B stays idle while rst_in is held low.
        disp_sel = rst_in & bus.disp_valid_in;
        proc_sel = rst_in & ~bus.disp_valid_in & bus.proc_req_in;

        addr_d = addr_q;
        if (disp_sel)      addr_d = bus.disp_addr_in;
        else if (proc_sel) addr_d = bus.proc_addr_in;

        tag_d    = tag_q;
        tag_d[0] = '{valid: disp_sel | proc_sel, owner: proc_sel ? OWNER_PROC : OWNER_DISP};
        for (int i = 1; i < int'(READ_LAT); i++) tag_d[i] = tag_q[i-1];

        cnt_d = '0;
        if (bus.proc_req_in && !proc_sel) cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        starve_d = starve_q | (cnt_d == CntMax);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            addr_q   <= '0;
            tag_q    <= '0;
            cnt_q    <= '0;
            starve_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    assign tag_out = tag_q[READ_LAT-1];

    assign bus.bram_en_out         = disp_sel | proc_sel;
    assign bus.bram_addr_out       = addr_d;
    assign bus.proc_gnt_out        = proc_sel;
    assign bus.proc_starve_out     = starve_q;
    assign bus.disp_data_valid_out = tag_out.valid & (tag_out.owner == OWNER_DISP);
    assign bus.proc_data_valid_out = tag_out.valid & (tag_out.owner == OWNER_PROC);
    assign bus.disp_data_out       = bus.disp_data_valid_out ? bus.bram_data_in : '0;
    assign bus.proc_data_out       = bus.proc_data_valid_out ? bus.bram_data_in : '0;

    fb_freeze_fsm u_freeze (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .freeze_req_in (bus.freeze_req_in),
        .frame_done_in (bus.frame_done_in),
        .cam_we_in     (bus.cam_we_in),
        .cam_we_out    (bus.cam_we_out),
        .frozen_out    (bus.frozen_out)
    );

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Randomised and directed bench for fb_read_arbiter against a cycle-level
// behavioural model: due-time read queue, denial run length and freeze flags.
module tb_fb_read_arbiter;
    import fb_arb_pkg::*;

    localparam int unsigned ADDR_W       = 17;
    localparam int unsigned DATA_W       = 16;
    localparam int unsigned READ_LAT     = 2;
    localparam int unsigned STARVE_LIMIT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fb_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_read_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .READ_LAT     (READ_LAT),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus)
    );

    function automatic logic [DATA_W-1:0] pix(input logic [ADDR_W-1:0] a);
        return a[DATA_W-1:0];
    endfunction

    // Two-stage BRAM: address register then output register.
    logic [ADDR_W-1:0] bram_a;
    always @(posedge clk) begin
        if (bus.bram_en_out) bram_a <= bus.bram_addr_out;
        bus.bram_data_in <= pix(bram_a);
    end

    typedef struct {
        int                due;
        bit                owner;
        logic [ADDR_W-1:0] addr;
    } rd_t;

    rd_t               q[$];
    int                cyc;
    logic [ADDR_W-1:0] m_last;
    int                m_denied;
    bit                m_starve, m_closed, m_frozen;
    int                n_total = 0;
    int                n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last   = '0;
        m_denied = 0;
        m_starve = 0;
        m_closed = 0;
        m_frozen = 0;
    endtask

    task automatic set_idle();
        bus.disp_valid_in = 0;
        bus.disp_addr_in  = '0;
        bus.proc_req_in   = 0;
        bus.proc_addr_in  = '0;
        bus.freeze_req_in = 0;
        bus.frame_done_in = 0;
        bus.cam_we_in     = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_en"}, 32'(bus.bram_en_out), 0);
        check_eq({tag, "_addr"}, 32'(bus.bram_addr_out), 0);
        check_eq({tag, "_gnt"}, 32'(bus.proc_gnt_out), 0);
        check_eq({tag, "_dval"}, 32'(bus.disp_data_valid_out), 0);
        check_eq({tag, "_ddata"}, 32'(bus.disp_data_out), 0);
        check_eq({tag, "_pval"}, 32'(bus.proc_data_valid_out), 0);
        check_eq({tag, "_pdata"}, 32'(bus.proc_data_out), 0);
        check_eq({tag, "_starve"}, 32'(bus.proc_starve_out), 0);
        check_eq({tag, "_camwe"}, 32'(bus.cam_we_out), 0);
        check_eq({tag, "_frozen"}, 32'(bus.frozen_out), 0);
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic tick();
        bit                m_en, m_gnt, dv, pv;
        logic [ADDR_W-1:0] m_addr;
        logic [DATA_W-1:0] dd, pd;
        rd_t               r;
        #3;
        m_gnt  = bus.proc_req_in && !bus.disp_valid_in;
        m_en   = bus.disp_valid_in || bus.proc_req_in;
        m_addr = bus.disp_valid_in ? bus.disp_addr_in : bus.proc_req_in ? bus.proc_addr_in : m_last;
        dv = 0; pv = 0; dd = '0; pd = '0;
        if (q.size() != 0 && q[0].due == cyc) begin
            r = q.pop_front();
            if (r.owner) begin pv = 1; pd = pix(r.addr); end
            else         begin dv = 1; dd = pix(r.addr); end
        end
        check_eq("gnt", 32'(bus.proc_gnt_out), 32'(m_gnt));
        check_eq("bram_en", 32'(bus.bram_en_out), 32'(m_en));
        check_eq("bram_addr", 32'(bus.bram_addr_out), 32'(m_addr));
        check_eq("disp_valid", 32'(bus.disp_data_valid_out), 32'(dv));
        check_eq("disp_data", 32'(bus.disp_data_out), 32'(dd));
        check_eq("proc_valid", 32'(bus.proc_data_valid_out), 32'(pv));
        check_eq("proc_data", 32'(bus.proc_data_out), 32'(pd));
        check_eq("starve", 32'(bus.proc_starve_out), 32'(m_starve));
        check_eq("cam_we", 32'(bus.cam_we_out), 32'(bus.cam_we_in && !m_closed));
        check_eq("frozen", 32'(bus.frozen_out), 32'(m_frozen));

        if (m_en) begin
            q.push_back('{due: cyc + int'(READ_LAT), owner: m_gnt, addr: m_addr});
            m_last = m_addr;
        end
        m_denied = (bus.proc_req_in && !m_gnt) ? m_denied + 1 : 0;
        if (m_denied >= int'(STARVE_LIMIT)) m_starve = 1;
        // Writes close only on a frame boundary and reopen only on one.
        if (!m_closed) begin
            if (bus.freeze_req_in && bus.frame_done_in) begin m_closed = 1; m_frozen = 1; end
        end else if (bus.freeze_req_in) m_frozen = 1;
        else if (m_frozen)              m_frozen = 0;
        else if (bus.frame_done_in)     m_closed = 0;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin : stim
        logic [ADDR_W-1:0] p_addr;
        bit                p_req, fr, g;

        cyc = 0;
        model_reset();
        set_idle();
        // Outputs must stay zero under reset even with every request asserted.
        #2;
        bus.disp_valid_in = 1; bus.disp_addr_in = 17'h1abc;
        bus.proc_req_in   = 1; bus.proc_addr_in = 17'h0123;
        bus.freeze_req_in = 1; bus.frame_done_in = 1; bus.cam_we_in = 1;
        #1;
        check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        set_idle();
        rst_n = 1;

        for (int i = 0; i < 10; i++) begin
            bus.disp_valid_in = 1; bus.disp_addr_in = ADDR_W'(i);
            tick();
        end
        set_idle();
        repeat (3) tick();

        p_addr = 100;
        for (int i = 0; i < 14; i++) begin
            bus.disp_valid_in = (i % 2 == 0);
            bus.disp_addr_in  = ADDR_W'(300 + i);
            bus.proc_req_in   = (p_addr <= 104);
            bus.proc_addr_in  = p_addr;
            g = bus.proc_req_in && !bus.disp_valid_in;
            tick();
            if (g) p_addr++;
        end
        set_idle();
        repeat (3) tick();

        for (int i = 0; i < 20; i++) begin
            bus.disp_valid_in = 1;
            bus.disp_addr_in  = ADDR_W'($urandom_range(0, FB_WIDTH * FB_HEIGHT - 1));
            bus.proc_req_in   = 1; bus.proc_addr_in = 17'd500;
            tick();
        end
        bus.disp_valid_in = 0;
        tick();
        set_idle();
        repeat (4) tick();

        bus.freeze_req_in = 1;
        for (int i = 0; i < 10; i++) begin bus.cam_we_in = 1'($urandom); tick(); end
        bus.frame_done_in = 1; bus.cam_we_in = 1;
        tick();
        bus.frame_done_in = 0;
        for (int i = 0; i < 1000; i++) begin bus.cam_we_in = (i % 2 == 0); tick(); end
        bus.freeze_req_in = 0; bus.cam_we_in = 1;
        repeat (5) tick();
        bus.freeze_req_in = 1;
        repeat (2) tick();
        bus.freeze_req_in = 0;
        repeat (3) tick();
        bus.frame_done_in = 1;
        tick();
        bus.frame_done_in = 0;
        repeat (3) tick();

        p_req = 0; p_addr = '0; fr = 0;
        for (int i = 0; i < 400; i++) begin
            if (!p_req && ($urandom % 3 == 0)) begin
                p_req  = 1;
                p_addr = ADDR_W'($urandom_range(0, FB_WIDTH * FB_HEIGHT - 1));
            end
            if ($urandom % 20 == 0) fr = !fr;
            bus.disp_valid_in = 1'($urandom);
            bus.disp_addr_in  = ADDR_W'($urandom_range(0, FB_WIDTH * FB_HEIGHT - 1));
            bus.proc_req_in   = p_req;
            bus.proc_addr_in  = p_addr;
            bus.freeze_req_in = fr;
            bus.frame_done_in = ($urandom % 15 == 0);
            bus.cam_we_in     = 1'($urandom);
            g = p_req && !bus.disp_valid_in;
            tick();
            if (g) p_req = 0;
        end
        set_idle();
        repeat (3) tick();

        // Reach FROZEN, put two reads in flight, then reset asynchronously.
        bus.freeze_req_in = 1; bus.frame_done_in = 1;
        tick();
        bus.frame_done_in = 0;
        bus.disp_valid_in = 1; bus.disp_addr_in = 17'd7;
        tick();
        bus.disp_valid_in = 0; bus.proc_req_in = 1; bus.proc_addr_in = 17'd9;
        tick();
        bus.disp_valid_in = 1; bus.cam_we_in = 1;
        #1;
        rst_n = 0;
        #1;
        check_all_zero("rst_mid");
        @(posedge clk); @(posedge clk); #1;
        set_idle();
        bus.cam_we_in = 1;
        rst_n = 1;
        model_reset();
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
